// File: rtl/uart_tx_feeder.sv
// Generic single-clock FIFO with level-based full/empty and synchronous flush.
// Latency: a written entry is visible at rd_dat on the cycle after the write edge.
// Backpressure: wr_rdy is low whenever level==DEPTH, even if a read happens in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    output logic          wr_rdy,
    output logic          rd_vld,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   level
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Full/empty come from the registered level only, so ready never depends on a same-cycle read.
    assign wr_rdy = (level != FULL_LVL);
    assign rd_vld = (level != '0);
    assign rd_dat = mem[rd_ptr];
    // A flush drops any write presented in the same cycle.
    assign push   = wr_vld & wr_rdy & ~flush;
    assign pop    = rd_vld & rd_rdy;

    // Storage array; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally at AW bits; level tracks occupancy and clears on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (!push && pop) begin
                level <= level - (AW+1)'(1);
            end
        end
    end
endmodule

// Byte queue and enable/data sequencer feeding uart_tx, with transmitter timeout detection.
// Latency: byte pushed into an empty idle FIFO at edge N raises tx_enable at edge N+1.
// Backpressure: in_ready low at level==DEPTH; one byte in flight until tx_active rises then falls.
module uart_tx_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    output logic          tx_enable,
    output logic [7:0]    tx_data,
    input  logic          tx_active,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          timeout_err,
    output logic [7:0]    err_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [9:0] TIMEOUT_V = 10'(TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  timer;
    logic [9:0]  timer_nxt;
    logic        tx_enable_nxt;
    logic [7:0]  tx_data_nxt;
    logic        timeout_err_nxt;
    logic [7:0]  err_count_nxt;
    logic        head_vld;
    logic [7:0]  head_dat;
    logic        pop;

    sync_fifo #(
        .W     (8),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .wr_vld (in_valid),
        .wr_dat (in_data),
        .wr_rdy (in_ready),
        .rd_vld (head_vld),
        .rd_rdy (pop),
        .rd_dat (head_dat),
        .level  (level)
    );

    assign busy = (state != IDLE) || (level != '0);

    // Next-state and registered-output logic; flush never aborts a byte already handed out.
    always_comb begin
        state_nxt       = state;
        timer_nxt       = timer;
        tx_enable_nxt   = tx_enable;
        tx_data_nxt     = tx_data;
        timeout_err_nxt = 1'b0;
        err_count_nxt   = err_count;
        pop             = 1'b0;
        case (state)
            IDLE: begin
                // Holding off while tx_active is high guarantees uart_tx never sees enable while busy.
                if (head_vld && !tx_active) begin
                    pop           = 1'b1;
                    tx_data_nxt   = head_dat;
                    tx_enable_nxt = 1'b1;
                    timer_nxt     = '0;
                    state_nxt     = ARM;
                end
            end
            ARM: begin
                if (tx_active) begin
                    tx_enable_nxt = 1'b0;
                    state_nxt     = ACTIVE;
                end else if (timer == TIMEOUT_V) begin
                    // Transmitter never responded: drop this byte and record the event.
                    tx_enable_nxt   = 1'b0;
                    timeout_err_nxt = 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count_nxt = err_count + 8'd1;
                    end
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 10'd1;
                end
            end
            ACTIVE: begin
                if (!tx_active) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops tx_enable immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            tx_enable   <= 1'b0;
            tx_data     <= 8'h00;
            timeout_err <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            tx_enable   <= tx_enable_nxt;
            tx_data     <= tx_data_nxt;
            timeout_err <= timeout_err_nxt;
            err_count   <= err_count_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: stub transmitter, byte scoreboard, directed scenarios.
// Latency: expected bytes are checked when tx_enable rises.
// Backpressure: producer waits on in_ready with a bounded loop.
module tb_uart_tx_feeder;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TO    = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic          tx_enable;
    logic [7:0]    tx_data;
    logic          tx_active;
    logic [AW:0]   level;
    logic          busy;
    logic          timeout_err;
    logic [7:0]    err_count;

    int            checks = 0;
    int            failures = 0;
    int            n_tx = 0;
    int            n_to = 0;
    int            stub_mode = 0;   // 0: never active, 1: respond to enable, 2: held high
    int            stub_len = 4;
    logic [7:0]    exp_q [$];

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_active   (tx_active),
        .level       (level),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Stub transmitter: reacts one edge after seeing tx_enable.
    initial begin : stub
        int cnt;
        cnt = 0;
        tx_active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                tx_active = 1'b0;
                cnt = 0;
            end else if (stub_mode == 0) begin
                tx_active = 1'b0;
                cnt = 0;
            end else if (stub_mode == 2) begin
                tx_active = 1'b1;
                cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_active = 1'b0;
            end else if (tx_enable) begin
                tx_active = 1'b1;
                cnt = stub_len;
            end else begin
                tx_active = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_enable rise and checks the handshake shape.
    initial begin : monitor
        logic       prev_en;
        logic       prev_act;
        logic [7:0] held;
        int         en_len;
        prev_en = 1'b0;
        prev_act = 1'b0;
        held = 8'h00;
        en_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
                en_len = 0;
            end else begin
                if (tx_enable && !prev_en) begin
                    check("enable_rise_while_tx_active_low", int'(prev_act), 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", tx_data);
                    end else begin
                        check("tx_byte_order", int'(tx_data), int'(exp_q.pop_front()));
                    end
                    held = tx_data;
                    en_len = 1;
                    n_tx++;
                end else if (tx_enable) begin
                    check("tx_data_stable", int'(tx_data), int'(held));
                    en_len++;
                end else if (prev_en) begin
                    if (stub_mode == 1) check("enable_len_active", en_len, 1);
                    else if (stub_mode == 0) check("enable_len_timeout", en_len, TO + 1);
                end
                if (timeout_err) n_to++;
                prev_en = tx_enable;
            end
            prev_act = tx_active;
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        int n = 0;
        in_valid = 1'b1;
        in_data = b;
        if (expect_tx) exp_q.push_back(b);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_stall_timeout: in_ready got 0 expected 1 for byte 0x%0h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0;
        int t0;
        int n;
        logic [7:0] t1 [4];
        int lv [4];
        t1 = '{8'h01, 8'h55, 8'h99, 8'hED};
        lv = '{1, 1, 2, 3};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_enable", int'(tx_enable), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_level", int'(level), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        check("rst_err_count", int'(err_count), 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: four bytes through a responding transmitter
        stub_mode = 1;
        stub_len = 4;
        n0 = n_tx;
        for (int i = 0; i < 4; i++) begin
            push_byte(t1[i], 1'b1);
            check("t1_level", int'(level), lv[i]);
        end
        wait_idle(300);
        check("t1_tx_active_low_at_idle", int'(tx_active), 0);
        check("t1_bytes_sent", n_tx - n0, 4);
        check("t1_no_timeouts", n_to, 0);
        check("t1_level_drained", int'(level), 0);

        // 2: silent transmitter, fill FIFO, stall, first timeout
        stub_mode = 0;
        n0 = n_tx;
        for (int i = 0; i < 9; i++) push_byte(8'(8'h10 + i), 1'b1);
        check("t2_level_full", int'(level), 8);
        check("t2_in_ready_full", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data = 8'h19;
        repeat (3) @(negedge clk);
        check("t2_stall_level", int'(level), 8);
        n = 0;
        while (!timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t2_timeout_pulse", int'(timeout_err), 1);
        check("t2_err_count_1", int'(err_count), 1);
        @(negedge clk);
        check("t2_timeout_one_cycle", int'(timeout_err), 0);
        check("t2_level_after_pop", int'(level), 7);
        push_byte(8'h19, 1'b1);
        wait_idle(400);
        check("t2_err_count_10", int'(err_count), 10);
        check("t2_timeouts", n_to, 10);
        check("t2_bytes_armed", n_tx - n0, 10);

        // 3: saturation of err_count
        t0 = n_to;
        for (int i = 0; i < 300; i++) push_byte(8'(i), 1'b1);
        wait_idle(400);
        check("t3_err_count_sat", int'(err_count), 'hFF);
        check("t3_timeout_pulses", n_to - t0, 300);

        // 4: flush during ACTIVE with a same-cycle push
        stub_mode = 1;
        stub_len = 20;
        n0 = n_tx;
        push_byte(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) push_byte(8'(8'hB0 + i), 1'b0);
        check("t4_level_5", int'(level), 5);
        check("t4_tx_active", int'(tx_active), 1);
        check("t4_enable_low_in_active", int'(tx_enable), 0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h77;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("t4_level_flushed", int'(level), 0);
        wait_idle(200);
        repeat (5) @(negedge clk);
        check("t4_only_a5_sent", n_tx - n0, 1);

        // 5a: push+pop at level 3; tx_active high in IDLE blocks the pop
        stub_mode = 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i), 1'b1);
        check("t5_level_3_held", int'(level), 3);
        check("t5_no_enable_while_active", int'(tx_enable), 0);
        stub_mode = 1;
        stub_len = 3;
        @(negedge clk);
        check("t5_level_3_pre", int'(level), 3);
        in_valid = 1'b1;
        in_data = 8'hC3;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_level_3_pushpop", int'(level), 3);
        check("t5_enable_up", int'(tx_enable), 1);
        wait_idle(300);

        // 5b: full FIFO rejects a push even when a pop happens that cycle
        stub_mode = 2;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) push_byte(8'(8'hD0 + i), 1'b1);
        check("t5_level_8", int'(level), 8);
        check("t5_in_ready_full", int'(in_ready), 0);
        in_valid = 1'b1;
        in_data = 8'hDD;
        stub_mode = 1;
        @(negedge clk);
        check("t5_level_8_pre", int'(level), 8);
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_full_push_rejected", int'(level), 7);
        wait_idle(500);

        // 6: reset during ARM
        stub_mode = 0;
        push_byte(8'h3C, 1'b1);
        push_byte(8'h3D, 1'b0);
        push_byte(8'h3E, 1'b0);
        check("t6_enable_in_arm", int'(tx_enable), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_enable_drop", int'(tx_enable), 0);
        check("t6_level_reset", int'(level), 0);
        check("t6_err_count_reset", int'(err_count), 0);
        check("t6_tx_data_reset", int'(tx_data), 0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        stub_mode = 1;
        stub_len = 4;
        n0 = n_tx;
        push_byte(8'h42, 1'b1);
        wait_idle(200);
        check("t6_after_reset_sent", n_tx - n0, 1);
        check("t6_err_count_zero", int'(err_count), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
